instr_encoder: RTL and testbench
================================

# instr_encoder

Packs decoded instruction fields (opcode, rs, rt, rd, immediate) into 16-bit instruction words and writes them sequentially into instruction memory. It is the encoding counterpart of the control decoder. A program loader or test harness streams instructions in over a valid/ready handshake. The block validates each beat, writes legal words through a registered imem write port at an auto-incrementing address, and keeps sticky error and completion status.

## Interface
- ADDR_W, default 8: instruction memory address width; capacity 2**ADDR_W words.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load session at address 0.
- in_valid  in  1  field beat valid.
- in_ready  out  1  block can accept a beat.
- in_op  in  4  opcode.
- in_rs  in  4  source register.
- in_rt  in  4  second source / I-type destination.
- in_rd  in  4  R-type destination.
- in_imm  in  12  immediate (I-type) or jump target (J-type).
- in_last  in  1  beat is the final instruction of the program.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  16  encoded instruction.
- count  out  ADDR_W+1  number of words written this session.
- done  out  1  session complete.
- full  out  1  session ended because memory capacity was exhausted.
- err_illegal  out  1  sticky: an illegal opcode was received.
- err_range  out  1  sticky: an immediate did not fit its field.

## Operation
- **States:**
  - IDLE: reset state, in_ready=0.
  - LOAD: accepting beats.
  - DONE: in_ready=0.
- **Transitions:**
  - IDLE or DONE, start=1 → LOAD. This clears wr_ptr, count, done, full, err_illegal and err_range.
  - start is ignored while in LOAD.
- **Acceptance:** a beat is accepted when in_valid && in_ready.
  - in_ready = (state==LOAD) && (wr_ptr < 2**ADDR_W).
- **Encoding by opcode:**
  - R-type, ops 0–3 (add/sub/and/or): {op, rs, rt, rd}.
  - I-type, ops 4, 5, 7, 8 (addi/beq/lw/sw): {op, rs, rt, imm[3:0]}.
    - Range check: imm[11:4] must all equal imm[3], i.e. the value is sign-extendable from 4 bits.
    - On violation the word is still written with imm truncated to imm[3:0], and err_range is set.
  - J-type, op 6 (j): {op, imm[11:0]}. No range check.
  - in_rd is ignored for I/J-type; in_rs, in_rt and in_rd are ignored for J-type.
- **Illegal opcodes (9–15):**
  - The beat is consumed but not written, and err_illegal is set.
  - wr_ptr and count do not advance.
  - in_last is still honoured.
- **Legal beat:** write at address wr_ptr, then wr_ptr += 1 and count += 1.
- **Session end:**
  - If the accepted beat has in_last=1, go to DONE; done=1.
  - If a legal beat fills slot 2**ADDR_W−1 with in_last=0, go to DONE with done=1 and full=1.
  - If in_last=1 on that final slot, full=0.
- **Error flags:** err_illegal and err_range stay set until start or rst.

## Timing
- **Reset values:** all outputs are 0 (in_ready, imem_we, imem_addr, imem_wdata, count, done, full, err_illegal, err_range); state=IDLE; wr_ptr=0.
- **Write latency:** a beat accepted at edge N produces imem_we=1 with registered imem_addr/imem_wdata during cycle N+1.
  - imem_we=0 in every cycle with no legal accepted beat.
  - imem_addr/imem_wdata hold their last values while imem_we=0.
- **Throughput:** one beat per cycle.
  - in_ready depends only on registered state.
  - No combinational path from in_valid to in_ready.
- **Status timing:** count, done, full and the error flags update at the same edge that registers the write (visible in cycle N+1).
- **Start:** start at edge S gives in_ready=1 from cycle S+1.
- **Back-to-back sessions:** start is permitted in the same cycle that done is first seen.
- **Reset mid-operation:** rst wins over all inputs.
  - A pending write is dropped: imem_we=0 in the cycle after rst.
  - Everything returns to reset values.
- **Capacity boundary:** in_ready falls in the cycle after the beat filling the last slot; a beat presented then is held off, not dropped.

## Test plan
- start; beat add rs=1 rt=2 rd=3 → next cycle imem_we=1, imem_addr=0, imem_wdata=0x0123, count=1.
- start; consecutive beats addi rs=2 rt=5 imm=0xFFD, then j imm=0xABC with in_last=1 → 0x425D at address 0, 0x6ABC at address 1 in consecutive cycles; done=1, count=2, in_ready=0; err_range=0.
- Beat op=0xA, then sw rs=1 rt=2 imm=4 → no write for the first beat; err_illegal=1; 0x8124 written at address 0; count=1.
- Beat addi rs=1 rt=1 imm=0x010 → 0x4110 written; err_range=1, held until the next start.
- ADDR_W=2: four legal beats with in_last=0 → addresses 0–3 written; done=1, full=1, count=4, in_ready=0; a fifth beat with in_valid held high is never accepted.
- rst asserted in cycle 2 of a streaming session with in_valid=1 → following cycle: imem_we=0, all outputs 0, state IDLE; a start afterwards writes from address 0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded fields into 16-bit words
// and streams them into instruction memory.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rt,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err_illegal,
  output logic              err_range
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_J    = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_full;
  logic              r_err_ill;
  logic              r_err_rng;

  logic        w_ready;
  logic        w_acc;
  logic        w_is_r;
  logic        w_is_i;
  logic        w_is_j;
  logic        w_legal;
  logic        w_imm_bad;
  logic        w_last_slot;
  logic        w_wr;
  logic        w_fin;
  logic        w_start;
  logic [15:0] w_word;

  // The write pointer and the word count always move
  // together, so one register serves as both; its top
  // bit set means every slot has been written.
  assign w_ready     = (r_state == S_LOAD) && !r_count[ADDR_W];
  assign w_acc       = in_valid && w_ready;
  assign w_last_slot = (r_count[ADDR_W-1:0] == '1);
  assign w_wr        = w_acc && w_legal;
  assign w_start     = start && (r_state != S_LOAD);
  assign w_fin       = w_acc && (in_last || (w_legal && w_last_slot));

  // Opcode class decode and immediate range check
  always_comb begin
    w_is_r    = 1'b0;
    w_is_i    = 1'b0;
    w_is_j    = 1'b0;
    w_imm_bad = 1'b0;
    if (in_op <= OP_OR) begin
      w_is_r = 1'b1;
    end
    if (in_op == OP_ADDI || in_op == OP_BEQ ||
        in_op == OP_LW   || in_op == OP_SW) begin
      w_is_i = 1'b1;
    end
    if (in_op == OP_J) begin
      w_is_j = 1'b1;
    end
    if (in_imm[11:4] != {8{in_imm[3]}}) begin
      w_imm_bad = 1'b1;
    end
  end

  assign w_legal = w_is_r || w_is_i || w_is_j;

  // Field packing per instruction format
  always_comb begin
    w_word = 16'h0000;
    unique case (1'b1)
      w_is_r:  w_word = {in_op, in_rs, in_rt, in_rd};
      w_is_i:  w_word = {in_op, in_rs, in_rt, in_imm[3:0]};
      w_is_j:  w_word = {in_op, in_imm};
      default: w_word = 16'h0000;
    endcase
  end

  // Session state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Session next-state: start opens a session, the last
  // beat or the final free slot closes it
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_fin) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write port, counter and sticky status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 16'h0000;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_full    <= 1'b0;
      r_err_ill <= 1'b0;
      r_err_rng <= 1'b0;
    end else begin
      r_we <= w_wr;
      if (w_start) begin
        r_count   <= '0;
        r_done    <= 1'b0;
        r_full    <= 1'b0;
        r_err_ill <= 1'b0;
        r_err_rng <= 1'b0;
      end else begin
        if (w_wr) begin
          r_addr  <= r_count[ADDR_W-1:0];
          r_wdata <= w_word;
          r_count <= r_count + (ADDR_W+1)'(1);
        end
        if (w_acc && !w_legal) begin
          r_err_ill <= 1'b1;
        end
        if (w_wr && w_is_i && w_imm_bad) begin
          r_err_rng <= 1'b1;
        end
        if (w_fin) begin
          r_done <= 1'b1;
          r_full <= w_legal && w_last_slot && !in_last;
        end
      end
    end
  end

  assign in_ready    = w_ready;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign count       = r_count;
  assign done        = r_done;
  assign full        = r_full;
  assign err_illegal = r_err_ill;
  assign err_range   = r_err_rng;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of instr_encoder
// at ADDR_W=8 and at ADDR_W=2 for the capacity boundary.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst, start, in_valid, in_last;
  logic [3:0]  in_op, in_rs, in_rt, in_rd;
  logic [11:0] in_imm;
  logic        in_ready, imem_we, done, full;
  logic        err_illegal, err_range;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [8:0]  count;

  logic        b_start, b_valid, b_last;
  logic [3:0]  b_op, b_rs, b_rt, b_rd;
  logic [11:0] b_imm;
  logic        b_ready, b_we, b_done, b_full;
  logic        b_eill, b_erng;
  logic [1:0]  b_addr;
  logic [15:0] b_wdata;
  logic [2:0]  b_count;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count),
    .done(done), .full(full),
    .err_illegal(err_illegal), .err_range(err_range)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(b_start),
    .in_valid(b_valid), .in_ready(b_ready),
    .in_op(b_op), .in_rs(b_rs), .in_rt(b_rt),
    .in_rd(b_rd), .in_imm(b_imm), .in_last(b_last),
    .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .count(b_count),
    .done(b_done), .full(b_full),
    .err_illegal(b_eill), .err_range(b_erng)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] op,
                      input logic [3:0] rs,
                      input logic [3:0] rt,
                      input logic [3:0] rd,
                      input logic [11:0] imm,
                      input logic last);
    in_valid = 1'b1;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_last = last;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_last = 1'b0; in_op = '0; in_rs = '0;
    in_rt = '0; in_rd = '0; in_imm = '0;
    b_start = 1'b0; b_valid = 1'b0; b_last = 1'b0;
    b_op = '0; b_rs = '0; b_rt = '0; b_rd = '0;
    b_imm = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset values
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags",
        32'({done, full, err_illegal, err_range}), 32'd0);

    // single add, last beat
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ready", 32'(in_ready), 32'd1);
    beat(4'd0, 4'd1, 4'd2, 4'd3, 12'h000, 1'b1);
    tick(); in_valid = 1'b0;
    chk("add_we", 32'(imem_we), 32'd1);
    chk("add_addr", 32'(imem_addr), 32'd0);
    chk("add_wdata", 32'(imem_wdata), 32'h0123);
    chk("add_count", 32'(count), 32'd1);
    chk("add_done", 32'(done), 32'd1);
    tick();
    chk("idle_we", 32'(imem_we), 32'd0);
    chk("hold_wdata", 32'(imem_wdata), 32'h0123);
    chk("done_ready", 32'(in_ready), 32'd0);

    // addi with negative imm then j as last
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    beat(4'd4, 4'd2, 4'd5, 4'd9, 12'hFFD, 1'b0);
    tick();
    chk("addi_we", 32'(imem_we), 32'd1);
    chk("addi_addr", 32'(imem_addr), 32'd0);
    chk("addi_wdata", 32'(imem_wdata), 32'h425D);
    beat(4'd6, 4'd7, 4'd7, 4'd7, 12'hABC, 1'b1);
    tick(); in_valid = 1'b0;
    chk("j_we", 32'(imem_we), 32'd1);
    chk("j_addr", 32'(imem_addr), 32'd1);
    chk("j_wdata", 32'(imem_wdata), 32'h6ABC);
    chk("j_count", 32'(count), 32'd2);
    chk("j_done", 32'(done), 32'd1);
    chk("j_ready", 32'(in_ready), 32'd0);
    chk("j_erng", 32'(err_range), 32'd0);

    // start in the cycle done is first seen
    start = 1'b1; tick(); start = 1'b0;
    chk("b2b_ready", 32'(in_ready), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);

    // illegal opcode then sw
    beat(4'hA, 4'd1, 4'd1, 4'd1, 12'h001, 1'b0);
    tick();
    chk("ill_we", 32'(imem_we), 32'd0);
    chk("ill_flag", 32'(err_illegal), 32'd1);
    chk("ill_count", 32'(count), 32'd0);
    beat(4'd8, 4'd1, 4'd2, 4'd0, 12'h004, 1'b0);
    tick();
    chk("sw_we", 32'(imem_we), 32'd1);
    chk("sw_addr", 32'(imem_addr), 32'd0);
    chk("sw_wdata", 32'(imem_wdata), 32'h8124);
    chk("sw_count", 32'(count), 32'd1);

    // addi immediate out of range
    beat(4'd4, 4'd1, 4'd1, 4'd0, 12'h010, 1'b1);
    tick(); in_valid = 1'b0;
    chk("rng_wdata", 32'(imem_wdata), 32'h4110);
    chk("rng_addr", 32'(imem_addr), 32'd1);
    chk("rng_flag", 32'(err_range), 32'd1);
    tick();
    chk("rng_sticky", 32'(err_range), 32'd1);
    chk("ill_sticky", 32'(err_illegal), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("clr_errs",
        32'({err_illegal, err_range}), 32'd0);

    // illegal opcode as last beat still ends session
    beat(4'hF, 4'd0, 4'd0, 4'd0, 12'h000, 1'b1);
    tick(); in_valid = 1'b0;
    chk("ill_last_done", 32'(done), 32'd1);
    chk("ill_last_we", 32'(imem_we), 32'd0);

    // reset in the middle of a stream
    start = 1'b1; tick(); start = 1'b0;
    beat(4'd1, 4'd4, 4'd5, 4'd6, 12'h000, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_we", 32'(imem_we), 32'd0);
    chk("mrst_out",
        32'({in_ready, imem_addr, imem_wdata, count}),
        32'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    beat(4'd0, 4'd1, 4'd2, 4'd7, 12'h000, 1'b1);
    tick(); in_valid = 1'b0;
    chk("post_rst_addr", 32'(imem_addr), 32'd0);
    chk("post_rst_wdata", 32'(imem_wdata), 32'h0127);

    // capacity boundary at ADDR_W=2
    b_start = 1'b1; tick(); b_start = 1'b0;
    b_valid = 1'b1; b_op = 4'd2; b_rs = 4'd3;
    b_rt = 4'd4; b_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_rd = 4'(k);
      tick();
      chk("cap_we", 32'(b_we), 32'd1);
      chk("cap_addr", 32'(b_addr), 32'(k));
      chk("cap_wdata", 32'(b_wdata), 32'h2340 + 32'(k));
    end
    chk("cap_done", 32'(b_done), 32'd1);
    chk("cap_full", 32'(b_full), 32'd1);
    chk("cap_count", 32'(b_count), 32'd4);
    chk("cap_ready", 32'(b_ready), 32'd0);
    b_rd = 4'd9;
    tick(); tick();
    chk("cap_hold_we", 32'(b_we), 32'd0);
    chk("cap_hold_count", 32'(b_count), 32'd4);
    chk("cap_hold_wdata", 32'(b_wdata), 32'h2343);
    b_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
